// File: rtl/dmem_sized.sv
// dmem_sized: RV32 byte/half/word data memory behind valid/ready handshakes.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them.
module dmem_sized #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = $clog2(DEPTH_BYTES);
  localparam int MW = 8 * DEPTH_BYTES;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);
  localparam logic [79:0] INIT_V = {
    8'd18, 8'd17, 8'd15, 8'd8, 8'd9,
    8'd11, 8'd20, 8'd12, 8'd9, 8'd10
  };

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  function automatic logic [MW-1:0] f_init();
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < 10; k++)
      if (4 * k < DEPTH_BYTES) m[32*k +: 8] = INIT_V[8*k +: 8];
    return m;
  endfunction

  localparam logic [MW-1:0] MEM_INIT = f_init();

  // Power-up image; never touched by reset.
  logic [MW-1:0] r_mem = MEM_INIT;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_fire;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic [1:0]        w_sz;
  logic [1:0]        w_len;
  logic [ADDR_W:0]   w_last;
  logic              w_oob;
  logic              w_bad_f3;
  logic              w_bad_st;
  logic              w_mis;
  logic              w_err;
  logic [IW-1:0]     w_i0, w_i1, w_i2, w_i3;
  logic [7:0]        w_b0, w_b1, w_b2, w_b3;
  logic [31:0]       w_load;

  assign req_ready = (r_state == S_IDLE) & rst_;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    unique case (r_state)
      S_IDLE: if (req_valid) begin
        w_state_nxt = S_BUSY;
        w_cnt_nxt   = CNT_INIT;
      end
      S_BUSY: if (r_cnt == 4'd0) begin
        w_state_nxt = S_RESP;
        w_fire      = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sz     = r_f3[1:0];
  assign w_len    = (w_sz == 2'b00) ? 2'd0 :
                    (w_sz == 2'b01) ? 2'd1 : 2'd3;
  assign w_bad_f3 = (w_sz == 2'b11) | (r_f3[2] & r_f3[1]);
  assign w_bad_st = r_we & r_f3[2];
  // Range check uses the address as issued, before any alignment.
  assign w_last   = {1'b0, r_addr} + {{(ADDR_W-1){1'b0}}, w_len};
  assign w_oob    = (w_last >= DEPTH_L);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = ((w_sz == 2'b01) & r_addr[0]) |
                 ((w_sz == 2'b10) & (r_addr[1:0] != 2'b00));
  assign w_i0  = r_addr[IW-1:0];
`else
  assign w_mis = 1'b0;
  assign w_i0  = r_addr[IW-1:0] & ~(IW'(w_len));
`endif

  assign w_err = w_bad_f3 | w_bad_st | w_oob | w_mis;
  assign w_i1  = w_i0 + IW'(1);
  assign w_i2  = w_i0 + IW'(2);
  assign w_i3  = w_i0 + IW'(3);
  assign w_b0  = r_mem[{w_i0, 3'b000} +: 8];
  assign w_b1  = r_mem[{w_i1, 3'b000} +: 8];
  assign w_b2  = r_mem[{w_i2, 3'b000} +: 8];
  assign w_b3  = r_mem[{w_i3, 3'b000} +: 8];

  always_comb begin
    w_load = '0;
    unique case (r_f3)
      3'b000:  w_load = {{24{w_b0[7]}}, w_b0};
      3'b001:  w_load = {{16{w_b1[7]}}, w_b1, w_b0};
      3'b010:  w_load = {w_b3, w_b2, w_b1, w_b0};
      3'b100:  w_load = {24'd0, w_b0};
      3'b101:  w_load = {16'd0, w_b1, w_b0};
      default: w_load = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (req_valid && req_ready) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_fire) begin
        r_err   <= w_err;
        r_rdata <= (w_err | r_we) ? 32'd0 : w_load;
      end
    end
  end

  // Stores commit only on the BUSY->RESP edge, and never under reset.
  always_ff @(posedge clk) begin
    if (w_fire && rst_ && r_we && !w_err) begin
      r_mem[{w_i0, 3'b000} +: 8] <= r_wdata[7:0];
      if (w_sz != 2'b00)
        r_mem[{w_i1, 3'b000} +: 8] <= r_wdata[15:8];
      if (w_sz == 2'b10) begin
        r_mem[{w_i2, 3'b000} +: 8] <= r_wdata[23:16];
        r_mem[{w_i3, 3'b000} +: 8] <= r_wdata[31:24];
      end
    end
  end
endmodule
